ex_ctrl_seq: RTL and testbench
==============================

# ex_ctrl_seq

Sequenced execute-stage controller for the MIPS datapath. It decodes `ALUOp_i`/`funct_i` into ALU control, immediate-extension, src1-mux and jump-register controls, registered with a valid/ready handshake. It owns an iterative signed multiplier, so SMUL occupies the block for `DATA_W` cycles while upstream stalls on `ready_o`. It sits between the main decoder and the ALU/writeback mux.

## Interface
- `DATA_W`, 32: operand and result width; SMUL takes exactly `DATA_W` iteration cycles.
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `valid_i`  in  1  operation presented this cycle.
- `ready_o`  out  1  block can accept; transfer on `valid_i && ready_o`.
- `ALUOp_i`  in  4  main-decoder op class (package encoding).
- `funct_i`  in  6  R-type funct field.
- `src_a_i`, `src_b_i`  in  DATA_W  multiplier operands (rs, rt values).
- `valid_o`  out  1  one-cycle pulse: decoded controls / product valid.
- `ALUCtrl_o`  out  4  ALU operation code.
- `Sign_extend_o`  out  1  1 = sign-extend immediate, 0 = zero-extend.
- `Mux_ALU_src1_o`  out  2  1 = shamt to ALU src1 (funct 000000/000011 only), else 0.
- `Jump_R_o`  out  1  jr decoded.
- `mul_result_o`  out  DATA_W  low word of signed product.
- `illegal_o`  out  1  only with `EX_CTRL_ILLEGAL_EN`.

## Operation
- States: IDLE, MUL, DONE. `ready_o` = (state != MUL).
- Accept in IDLE/DONE, non-SMUL: decode registered; next state DONE (valid_o=1 next cycle), then IDLE if no new accept.
- Accept of R-type funct 011000 (SMUL): latch |a|, |b|, sign = a[MSB]^b[MSB]; ALUCtrl_o=A_SMUL registered at acceptance; enter MUL with counter=0.
- MUL: each cycle add shifted multiplicand if multiplier LSB set, shift, counter++; after `DATA_W`th iteration → DONE with `mul_result_o` = sign ? −acc : acc (low `DATA_W` bits).
- Magnitude of most-negative operand (2^(DATA_W−1)) is exact in unsigned `DATA_W` bits; no overflow flag, result truncated.
- Accept in DONE legal (back-to-back); valid_o pulses for the completing op, new op starts.
- Decode: R-type 100001→A_ADDU, 100011→A_SUBU, 100100→A_AND, 100101→A_OR, 101010→A_SLT, 000011→A_SRA, 000111→A_SRAV, 000000→A_SLL, 011000→A_SMUL, 001000→Jump_R_o=1 with A_ADDU; Sign_extend_o=0 for all R-type.
- ADDI→A_ADDU/sx1; SLTIU→A_SLTU/sx0; BEQ,BNE→A_SUBU/sx1; LUI→A_LUI/sx0; ORI→A_OR/sx0; LW→A_LW/sx1; SW→A_SW/sx1; BLEZ→A_BLEZ/sx1; BGTZ→A_BGTZ/sx1; JRS,J,JAL→A_ADDU/sx1.
- Unknown funct/ALUOp: A_AND, sx0, Jump_R_o=0, src1 mux 0 (never holds stale values).
- Outputs hold between valid pulses until next accept; `mul_result_o` changes only on SMUL completion.

## Timing
- Reset values: state IDLE, `ready_o`=1, `valid_o`=0, `ALUCtrl_o`=0, `Sign_extend_o`=0, `Mux_ALU_src1_o`=0, `Jump_R_o`=0, `mul_result_o`=0, `illegal_o`=0.
- Non-SMUL latency 1: accept edge N → valid_o high cycle N+1.
- SMUL latency `DATA_W`+1: accept edge N → ready_o low cycles N+1..N+DATA_W → valid_o high and ready_o high cycle N+DATA_W+1.
- Reset mid-MUL: aborts; next cycle all outputs at reset values; no late valid_o pulse.
- `valid_i` ignored while `ready_o`=0; upstream holds its op.

## Configuration
- `EX_CTRL_ILLEGAL_EN` defined: `illegal_o` port present, registered with the decode, 1 for unknown ALUOp or unknown R-type funct, valid alongside `valid_o`.
- Undefined: port and logic absent; unknown codes decode silently to defaults above.

## Structure
- `ex_ctrl_pkg`: ALU codes (A_AND=0, A_OR=1, A_LW=2, A_SW=3, A_ADDU=4, A_SUBU=5, A_SLT=6, A_BLEZ=7, A_SRA=8, A_SRAV=9, A_LUI=10, A_SLTU=11, A_SLL=12, A_SMUL=13, A_BGTZ=14); ALUOp codes (R_TYPE=0, ADDI=1, SLTIU=2, BEQ=3, LUI=4, ORI=5, BNE=6, LW=7, SW=8, BLEZ=9, BGTZ=10, JRS=11, J=12, JAL=13); funct constants; state enum.
- Sub-module `seq_mul`: iterative shift-add signed multiplier (start/done, `DATA_W` param); decode and FSM stay in top.

## Test plan
- After reset, ALUOp=0, funct=100001 accepted → next cycle valid_o=1, ALUCtrl_o=4, Sign_extend_o=0, Mux_ALU_src1_o=0, ready_o=1.
- funct=000011 then ALUOp=ORI back-to-back → ALUCtrl_o=8/src1 mux 1, then ALUCtrl_o=1/sx0/mux 0 on consecutive cycles.
- SMUL a=0xFFFFFFFD, b=7 → ready_o low 32 cycles, valid_o on cycle 33, mul_result_o=0xFFFFFFEB.
- SMUL a=0x80000000, b=0xFFFFFFFF → mul_result_o=0x80000000; new ADDI accepted in DONE → valid_o next cycle, ALUCtrl_o=4, sx1.
- rst_i for one cycle at iteration 10 of SMUL → following cycle ready_o=1, all outputs reset values; no valid_o for 40 cycles.
- ALUOp=15 with `EX_CTRL_ILLEGAL_EN` → illegal_o=1, ALUCtrl_o=0; funct=001000 → Jump_R_o=1, illegal_o=0.

Source files
------------

// File: rtl/ex_ctrl_seq_pkg.sv
// ex_ctrl_pkg: shared encodings and decode helper for the execute-stage controller.
// ALU control codes, main-decoder op classes, R-type funct values, FSM state type.
package ex_ctrl_pkg;

   // ALU control codes
   localparam logic [3:0] A_AND  = 4'd0;
   localparam logic [3:0] A_OR   = 4'd1;
   localparam logic [3:0] A_LW   = 4'd2;
   localparam logic [3:0] A_SW   = 4'd3;
   localparam logic [3:0] A_ADDU = 4'd4;
   localparam logic [3:0] A_SUBU = 4'd5;
   localparam logic [3:0] A_SLT  = 4'd6;
   localparam logic [3:0] A_BLEZ = 4'd7;
   localparam logic [3:0] A_SRA  = 4'd8;
   localparam logic [3:0] A_SRAV = 4'd9;
   localparam logic [3:0] A_LUI  = 4'd10;
   localparam logic [3:0] A_SLTU = 4'd11;
   localparam logic [3:0] A_SLL  = 4'd12;
   localparam logic [3:0] A_SMUL = 4'd13;
   localparam logic [3:0] A_BGTZ = 4'd14;

   // Main-decoder op classes
   localparam logic [3:0] R_TYPE = 4'd0;
   localparam logic [3:0] ADDI   = 4'd1;
   localparam logic [3:0] SLTIU  = 4'd2;
   localparam logic [3:0] BEQ    = 4'd3;
   localparam logic [3:0] LUI    = 4'd4;
   localparam logic [3:0] ORI    = 4'd5;
   localparam logic [3:0] BNE    = 4'd6;
   localparam logic [3:0] LW     = 4'd7;
   localparam logic [3:0] SW     = 4'd8;
   localparam logic [3:0] BLEZ   = 4'd9;
   localparam logic [3:0] BGTZ   = 4'd10;
   localparam logic [3:0] JRS    = 4'd11;
   localparam logic [3:0] J      = 4'd12;
   localparam logic [3:0] JAL    = 4'd13;

   // R-type funct values
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_SRAV = 6'b000111;
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SMUL = 6'b011000;
   localparam logic [5:0] F_JR   = 6'b001000;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

   typedef struct packed {
      logic [3:0] alu_ctrl;
      logic       sign_ext;
      logic [1:0] src1;
      logic       jump_r;
      logic       illegal;
   } dec_t;

   // Full decode; every field starts at its default so unknown codes never keep old values
   function automatic dec_t decode(input logic [3:0] alu_op, input logic [5:0] funct);
      dec_t d;
      d.alu_ctrl = A_AND;
      d.sign_ext = 1'b0;
      d.src1     = 2'd0;
      d.jump_r   = 1'b0;
      d.illegal  = 1'b0;
      case (alu_op)
         R_TYPE: begin
            case (funct)
               F_ADDU: d.alu_ctrl = A_ADDU;
               F_SUBU: d.alu_ctrl = A_SUBU;
               F_AND:  d.alu_ctrl = A_AND;
               F_OR:   d.alu_ctrl = A_OR;
               F_SLT:  d.alu_ctrl = A_SLT;
               F_SRA:  begin d.alu_ctrl = A_SRA; d.src1 = 2'd1; end
               F_SRAV: d.alu_ctrl = A_SRAV;
               F_SLL:  begin d.alu_ctrl = A_SLL; d.src1 = 2'd1; end
               F_SMUL: d.alu_ctrl = A_SMUL;
               F_JR:   begin d.alu_ctrl = A_ADDU; d.jump_r = 1'b1; end
               default: d.illegal = 1'b1;
            endcase
         end
         ADDI:          begin d.alu_ctrl = A_ADDU; d.sign_ext = 1'b1; end
         SLTIU:         d.alu_ctrl = A_SLTU;
         BEQ, BNE:      begin d.alu_ctrl = A_SUBU; d.sign_ext = 1'b1; end
         LUI:           d.alu_ctrl = A_LUI;
         ORI:           d.alu_ctrl = A_OR;
         LW:            begin d.alu_ctrl = A_LW;   d.sign_ext = 1'b1; end
         SW:            begin d.alu_ctrl = A_SW;   d.sign_ext = 1'b1; end
         BLEZ:          begin d.alu_ctrl = A_BLEZ; d.sign_ext = 1'b1; end
         BGTZ:          begin d.alu_ctrl = A_BGTZ; d.sign_ext = 1'b1; end
         JRS, J, JAL:   begin d.alu_ctrl = A_ADDU; d.sign_ext = 1'b1; end
         default:       d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/ex_ctrl_seq_mul.sv
// seq_mul: iterative shift-add signed multiplier on operand magnitudes.
// One iteration per cycle after start; done_o is high during the last iteration and
// product_o then carries the sign-corrected low word of the final accumulator.
module seq_mul #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic              done_o,
   output logic [DATA_W-1:0] product_o
);

   localparam int unsigned CNT_W = $clog2(DATA_W);

   logic              r_busy;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0] r_mplier;
   logic [DATA_W-1:0] r_acc;
   logic              r_neg;

   logic [DATA_W-1:0] w_abs_a;
   logic [DATA_W-1:0] w_abs_b;
   logic [DATA_W-1:0] w_acc_next;
   logic              w_last;

   // Most-negative input stays 2^(DATA_W-1), which is its exact unsigned magnitude
   assign w_abs_a    = a_i[DATA_W-1] ? ({DATA_W{1'b0}} - a_i) : a_i;
   assign w_abs_b    = b_i[DATA_W-1] ? ({DATA_W{1'b0}} - b_i) : b_i;
   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_last     = r_busy && (r_cnt == CNT_W'(DATA_W - 1));
   assign done_o     = w_last;
   assign product_o  = r_neg ? ({DATA_W{1'b0}} - w_acc_next) : w_acc_next;

   // Operand latch on start, then one shift-add step per cycle while busy
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_neg    <= 1'b0;
      end else if (start_i) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_mcand  <= w_abs_a;
         r_mplier <= w_abs_b;
         r_acc    <= '0;
         r_neg    <= a_i[DATA_W-1] ^ b_i[DATA_W-1];
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (w_last) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_ctrl_seq.sv
// ex_ctrl_seq: execute-stage control decode with valid/ready handshake and an owned
// iterative signed multiplier. Optional feature macro: EX_CTRL_ILLEGAL_EN adds illegal_o.
module ex_ctrl_seq
   import ex_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [3:0]        ALUOp_i,
   input  logic [5:0]        funct_i,
   input  logic [DATA_W-1:0] src_a_i,
   input  logic [DATA_W-1:0] src_b_i,
   output logic              valid_o,
   output logic [3:0]        ALUCtrl_o,
   output logic              Sign_extend_o,
   output logic [1:0]        Mux_ALU_src1_o,
   output logic              Jump_R_o,
   output logic [DATA_W-1:0] mul_result_o
`ifdef EX_CTRL_ILLEGAL_EN
   ,
   output logic              illegal_o
`endif
);

   state_e            r_state;
   logic              r_valid;
   logic [3:0]        r_alu_ctrl;
   logic              r_sign_ext;
   logic [1:0]        r_src1;
   logic              r_jump_r;
   logic [DATA_W-1:0] r_mul_result;

   dec_t              w_dec;
   logic              w_accept;
   logic              w_is_smul;
   logic              w_mul_done;
   logic [DATA_W-1:0] w_product;

   assign ready_o   = (r_state != S_MUL);
   assign w_accept  = valid_i && ready_o;
   assign w_is_smul = (ALUOp_i == R_TYPE) && (funct_i == F_SMUL);
   assign w_dec     = decode(ALUOp_i, funct_i);

   seq_mul #(
      .DATA_W (DATA_W)
   ) u_seq_mul (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (w_accept && w_is_smul),
      .a_i       (src_a_i),
      .b_i       (src_b_i),
      .done_o    (w_mul_done),
      .product_o (w_product)
   );

   // Control FSM with registered decode outputs; valid pulses one cycle per completed op
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_valid      <= 1'b0;
         r_alu_ctrl   <= A_AND;
         r_sign_ext   <= 1'b0;
         r_src1       <= 2'd0;
         r_jump_r     <= 1'b0;
         r_mul_result <= '0;
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_alu_ctrl <= w_dec.alu_ctrl;
                  r_sign_ext <= w_dec.sign_ext;
                  r_src1     <= w_dec.src1;
                  r_jump_r   <= w_dec.jump_r;
                  if (w_is_smul) begin
                     r_state <= S_MUL;
                  end else begin
                     r_state <= S_DONE;
                     r_valid <= 1'b1;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_MUL: begin
               if (w_mul_done) begin
                  r_state      <= S_DONE;
                  r_valid      <= 1'b1;
                  r_mul_result <= w_product;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign valid_o        = r_valid;
   assign ALUCtrl_o      = r_alu_ctrl;
   assign Sign_extend_o  = r_sign_ext;
   assign Mux_ALU_src1_o = r_src1;
   assign Jump_R_o       = r_jump_r;
   assign mul_result_o   = r_mul_result;

`ifdef EX_CTRL_ILLEGAL_EN
   logic r_illegal;

   // Illegal flag registered alongside the rest of the decode
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_illegal <= 1'b0;
      end else if (w_accept) begin
         r_illegal <= w_dec.illegal;
      end
   end

   assign illegal_o = r_illegal;
`else
   logic w_unused;
   assign w_unused = w_dec.illegal;
`endif

endmodule

// File: tb/tb_ex_ctrl_seq.sv
// Directed self-checking bench for ex_ctrl_seq (DATA_W = 32).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ex_ctrl_seq;
   import ex_ctrl_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [3:0]  ALUOp_i;
   logic [5:0]  funct_i;
   logic [31:0] src_a_i;
   logic [31:0] src_b_i;
   logic        valid_o;
   logic [3:0]  ALUCtrl_o;
   logic        Sign_extend_o;
   logic [1:0]  Mux_ALU_src1_o;
   logic        Jump_R_o;
   logic [31:0] mul_result_o;
`ifdef EX_CTRL_ILLEGAL_EN
   logic        illegal_o;
`endif

   int checks   = 0;
   int failures = 0;
   int low_cnt;
   int vld_cnt;

   always #5 clk_i = ~clk_i;

   ex_ctrl_seq #(
      .DATA_W (32)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .ALUOp_i        (ALUOp_i),
      .funct_i        (funct_i),
      .src_a_i        (src_a_i),
      .src_b_i        (src_b_i),
      .valid_o        (valid_o),
      .ALUCtrl_o      (ALUCtrl_o),
      .Sign_extend_o  (Sign_extend_o),
      .Mux_ALU_src1_o (Mux_ALU_src1_o),
      .Jump_R_o       (Jump_R_o),
      .mul_result_o   (mul_result_o)
`ifdef EX_CTRL_ILLEGAL_EN
      ,
      .illegal_o      (illegal_o)
`endif
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(ready_o), 32'd1);
      chk({tag, "_valid"}, 32'(valid_o), 32'd0);
      chk({tag, "_alu"}, 32'(ALUCtrl_o), 32'd0);
      chk({tag, "_sx"}, 32'(Sign_extend_o), 32'd0);
      chk({tag, "_mux"}, 32'(Mux_ALU_src1_o), 32'd0);
      chk({tag, "_jr"}, 32'(Jump_R_o), 32'd0);
      chk({tag, "_mul"}, mul_result_o, 32'd0);
`ifdef EX_CTRL_ILLEGAL_EN
      chk({tag, "_ill"}, 32'(illegal_o), 32'd0);
`endif
   endtask

   initial begin
      rst_i   = 1'b1;
      valid_i = 1'b0;
      ALUOp_i = R_TYPE;
      funct_i = 6'd0;
      src_a_i = 32'd0;
      src_b_i = 32'd0;
      repeat (2) tick();
      rst_i = 1'b0;
      chk_reset_vals("rst");

      // ADDU
      valid_i = 1'b1; ALUOp_i = R_TYPE; funct_i = 6'b100001;
      tick();
      chk("addu_valid", 32'(valid_o), 32'd1);
      chk("addu_alu", 32'(ALUCtrl_o), 32'd4);
      chk("addu_sx", 32'(Sign_extend_o), 32'd0);
      chk("addu_mux", 32'(Mux_ALU_src1_o), 32'd0);
      chk("addu_ready", 32'(ready_o), 32'd1);

      // SRA then ORI back-to-back
      funct_i = 6'b000011;
      tick();
      chk("sra_valid", 32'(valid_o), 32'd1);
      chk("sra_alu", 32'(ALUCtrl_o), 32'd8);
      chk("sra_mux", 32'(Mux_ALU_src1_o), 32'd1);
      ALUOp_i = ORI; funct_i = 6'd0;
      tick();
      chk("ori_valid", 32'(valid_o), 32'd1);
      chk("ori_alu", 32'(ALUCtrl_o), 32'd1);
      chk("ori_sx", 32'(Sign_extend_o), 32'd0);
      chk("ori_mux", 32'(Mux_ALU_src1_o), 32'd0);
      valid_i = 1'b0;
      tick();
      chk("idle_valid", 32'(valid_o), 32'd0);
      chk("idle_hold_alu", 32'(ALUCtrl_o), 32'd1);

      // SMUL -3 * 7
      valid_i = 1'b1; ALUOp_i = R_TYPE; funct_i = 6'b011000;
      src_a_i = 32'hFFFF_FFFD; src_b_i = 32'd7;
      tick();
      valid_i = 1'b0;
      chk("smul1_alu", 32'(ALUCtrl_o), 32'd13);
      low_cnt = (ready_o === 1'b0) ? 1 : 0;
      vld_cnt = (valid_o === 1'b1) ? 1 : 0;
      for (int i = 0; i < 31; i++) begin
         tick();
         if (ready_o === 1'b0) low_cnt++;
         if (valid_o === 1'b1) vld_cnt++;
      end
      chk("smul1_busy_cycles", 32'(low_cnt), 32'd32);
      chk("smul1_early_valid", 32'(vld_cnt), 32'd0);
      tick();
      chk("smul1_valid", 32'(valid_o), 32'd1);
      chk("smul1_ready", 32'(ready_o), 32'd1);
      chk("smul1_result", mul_result_o, 32'hFFFF_FFEB);
      tick();
      chk("smul1_pulse_end", 32'(valid_o), 32'd0);
      chk("smul1_hold", mul_result_o, 32'hFFFF_FFEB);

      // SMUL most-negative * -1, ADDI presented during MUL and accepted in DONE
      valid_i = 1'b1; ALUOp_i = R_TYPE; funct_i = 6'b011000;
      src_a_i = 32'h8000_0000; src_b_i = 32'hFFFF_FFFF;
      tick();
      valid_i = 1'b0;
      repeat (30) tick();
      valid_i = 1'b1; ALUOp_i = ADDI; funct_i = 6'd0;
      src_a_i = 32'd0; src_b_i = 32'd0;
      tick();
      chk("smul2_stall_ready", 32'(ready_o), 32'd0);
      tick();
      chk("smul2_valid", 32'(valid_o), 32'd1);
      chk("smul2_result", mul_result_o, 32'h8000_0000);
      chk("smul2_alu", 32'(ALUCtrl_o), 32'd13);
      tick();
      valid_i = 1'b0;
      chk("addi_valid", 32'(valid_o), 32'd1);
      chk("addi_alu", 32'(ALUCtrl_o), 32'd4);
      chk("addi_sx", 32'(Sign_extend_o), 32'd1);
      chk("addi_mul_hold", mul_result_o, 32'h8000_0000);

      // Reset during SMUL iteration 10
      valid_i = 1'b1; ALUOp_i = R_TYPE; funct_i = 6'b011000;
      src_a_i = 32'd5; src_b_i = 32'd3;
      tick();
      valid_i = 1'b0;
      repeat (9) tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk_reset_vals("midrst");
      vld_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (valid_o !== 1'b0) vld_cnt++;
      end
      chk("midrst_no_valid", 32'(vld_cnt), 32'd0);

      // LW, JR, then unknown ALUOp
      valid_i = 1'b1; ALUOp_i = LW; funct_i = 6'd0;
      tick();
      chk("lw_alu", 32'(ALUCtrl_o), 32'd2);
      chk("lw_sx", 32'(Sign_extend_o), 32'd1);
      ALUOp_i = R_TYPE; funct_i = 6'b001000;
      tick();
      chk("jr_jr", 32'(Jump_R_o), 32'd1);
      chk("jr_alu", 32'(ALUCtrl_o), 32'd4);
      chk("jr_sx", 32'(Sign_extend_o), 32'd0);
`ifdef EX_CTRL_ILLEGAL_EN
      chk("jr_ill", 32'(illegal_o), 32'd0);
`endif
      ALUOp_i = 4'd15; funct_i = 6'd0;
      tick();
      valid_i = 1'b0;
      chk("unk_valid", 32'(valid_o), 32'd1);
      chk("unk_alu", 32'(ALUCtrl_o), 32'd0);
      chk("unk_sx", 32'(Sign_extend_o), 32'd0);
      chk("unk_jr", 32'(Jump_R_o), 32'd0);
      chk("unk_mux", 32'(Mux_ALU_src1_o), 32'd0);
`ifdef EX_CTRL_ILLEGAL_EN
      chk("unk_ill", 32'(illegal_o), 32'd1);
`endif
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
